// File: rtl/preg_stage_hs.sv
// Pipeline stage register with valid/ready handshake, synchronous flush, optional
// two-entry skid buffer and saturating stall/flush counters.
module preg_stage_hs #(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 64,
  parameter bit SKID_EN    = 1'b1,
  parameter bit CLEAR_DATA = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } st_t;

  st_t               st_q;
  st_t               st_d;
  logic              in_fire;
  logic              out_fire;
  logic              main_vld;
  logic              skid_vld;
  logic              ld_main_in;
  logic              ld_main_skid;
  logic              clr_main;
  logic              ld_skid;
  logic              clr_skid;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  assign main_vld = (st_q != ST_EMPTY);
  assign skid_vld = (st_q == ST_FULL);
  assign in_fire  = i_valid & o_ready;
  assign out_fire = main_vld & i_ready;

  generate
    if (SKID_EN) begin : g_skid_ready
      // Registered ready: deasserts exactly while the skid entry is occupied.
      logic rdy_q;
      always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) rdy_q <= 1'b1;
        else        rdy_q <= (st_d != ST_FULL);
      end
      assign o_ready = rdy_q;
    end else begin : g_comb_ready
      assign o_ready = !main_vld | i_ready;
    end
  endgenerate

  // State register
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) st_q <= ST_EMPTY;
    else        st_q <= st_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_EMPTY: if (in_fire) st_d = ST_ONE;
      ST_ONE: begin
        if (out_fire && !in_fire)                 st_d = ST_EMPTY;
        else if (in_fire && !out_fire && SKID_EN) st_d = ST_FULL;
      end
      ST_FULL:  if (out_fire) st_d = ST_ONE;
      default:  st_d = ST_EMPTY;
    endcase
    if (i_flush) st_d = ST_EMPTY;
  end

  // Entry load/clear strobes derived from the current state
  always_comb begin
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    clr_main     = 1'b0;
    ld_skid      = 1'b0;
    clr_skid     = 1'b0;
    if (!i_flush) begin
      case (st_q)
        ST_EMPTY: ld_main_in = in_fire;
        ST_ONE: begin
          if (in_fire && out_fire)  ld_main_in = 1'b1;
          else if (out_fire)        clr_main   = 1'b1;
          else if (in_fire)         ld_skid    = SKID_EN;
        end
        ST_FULL: begin
          if (out_fire) begin
            ld_main_skid = 1'b1;
            clr_skid     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Main entry: drives the outputs directly
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else if (i_flush || clr_main) begin
      main_ctrl_q <= '0;
      if (CLEAR_DATA) main_data_q <= '0;
    end else if (ld_main_in) begin
      main_ctrl_q <= i_ctrl;
      main_data_q <= i_data;
    end else if (ld_main_skid) begin
      main_ctrl_q <= skid_ctrl_q;
      main_data_q <= skid_data_q;
    end
  end

  // Skid entry: absorbs the beat accepted while the output is stalled
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (i_flush || clr_skid) begin
      skid_ctrl_q <= '0;
      if (CLEAR_DATA) skid_data_q <= '0;
    end else if (ld_skid) begin
      skid_ctrl_q <= i_ctrl;
      skid_data_q <= i_data;
    end
  end

  // Performance counters, cleared only by reset
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (main_vld && !i_ready) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (i_flush)              flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign o_valid     = main_vld;
  assign o_ctrl      = main_ctrl_q;
  assign o_data      = main_data_q;
  assign o_occupancy = {1'b0, main_vld} + {1'b0, skid_vld};
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_preg_stage_hs.sv
// Directed bench for preg_stage_hs: a skid-buffer instance (4-bit counters) and a
// combinational-ready instance with data clearing, both checked against queue models.
module tb_preg_stage_hs;
  localparam int CW = 16;
  localparam int DW = 64;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic          a_i_flush, a_i_valid, a_o_ready, a_o_valid, a_i_ready;
  logic [CW-1:0] a_i_ctrl, a_o_ctrl;
  logic [DW-1:0] a_i_data, a_o_data;
  logic [1:0]    a_o_occ;
  logic [3:0]    a_stall_cnt, a_flush_cnt;

  logic          b_i_flush, b_i_valid, b_o_ready, b_o_valid, b_i_ready;
  logic [CW-1:0] b_i_ctrl, b_o_ctrl;
  logic [DW-1:0] b_i_data, b_o_data;
  logic [1:0]    b_o_occ;
  logic [15:0]   b_stall_cnt, b_flush_cnt;

  preg_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1), .CLEAR_DATA(1'b0), .CNT_W(4)) u_dut_a (
    .i_clk(clk), .i_arst(arst), .i_flush(a_i_flush), .i_valid(a_i_valid), .o_ready(a_o_ready),
    .i_ctrl(a_i_ctrl), .i_data(a_i_data), .o_valid(a_o_valid), .i_ready(a_i_ready),
    .o_ctrl(a_o_ctrl), .o_data(a_o_data), .o_occupancy(a_o_occ),
    .o_stall_cnt(a_stall_cnt), .o_flush_cnt(a_flush_cnt)
  );

  preg_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0), .CLEAR_DATA(1'b1), .CNT_W(16)) u_dut_b (
    .i_clk(clk), .i_arst(arst), .i_flush(b_i_flush), .i_valid(b_i_valid), .o_ready(b_o_ready),
    .i_ctrl(b_i_ctrl), .i_data(b_i_data), .o_valid(b_o_valid), .i_ready(b_i_ready),
    .o_ctrl(b_o_ctrl), .o_data(b_o_data), .o_occupancy(b_o_occ),
    .o_stall_cnt(b_stall_cnt), .o_flush_cnt(b_flush_cnt)
  );

  beat_t       qa[$];
  beat_t       qb[$];
  logic [DW-1:0] a_last;
  int a_stall, a_flush, b_stall, b_flush;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_models();
    qa.delete();
    qb.delete();
    a_last  = '0;
    a_stall = 0;
    a_flush = 0;
    b_stall = 0;
    b_flush = 0;
  endtask

  // Called at posedge+1; checks mid-cycle, then advances the models across the edge.
  task automatic cyc();
    logic a_v, a_r, a_in, a_out, a_fl, a_ir, b_v, b_r, b_in, b_out, b_fl, b_ir;
    logic [CW-1:0] ec, a_c, b_c;
    logic [DW-1:0] ed, a_d, b_d;
    #3;
    a_v = (qa.size() > 0);
    a_r = (qa.size() < 2);
    ec = '0;
    ed = a_last;
    if (a_v) begin
      ec = qa[0].c;
      ed = qa[0].d;
    end
    chk("a_valid", a_o_valid, a_v);
    chk("a_ctrl", a_o_ctrl, ec);
    chk("a_data", a_o_data, ed);
    chk("a_ready", a_o_ready, a_r);
    chk("a_occ", a_o_occ, qa.size());
    chk("a_stall_cnt", a_stall_cnt, a_stall);
    chk("a_flush_cnt", a_flush_cnt, a_flush);

    b_v = (qb.size() > 0);
    b_r = (qb.size() == 0) || b_i_ready;
    ec = '0;
    ed = '0;
    if (b_v) begin
      ec = qb[0].c;
      ed = qb[0].d;
    end
    chk("b_valid", b_o_valid, b_v);
    chk("b_ctrl", b_o_ctrl, ec);
    chk("b_data", b_o_data, ed);
    chk("b_ready", b_o_ready, b_r);
    chk("b_occ", b_o_occ, qb.size());
    chk("b_stall_cnt", b_stall_cnt, b_stall);
    chk("b_flush_cnt", b_flush_cnt, b_flush);

    a_in = a_i_valid && a_r;  a_out = a_v && a_i_ready;  a_fl = a_i_flush;  a_ir = a_i_ready;
    a_c = a_i_ctrl;  a_d = a_i_data;
    b_in = b_i_valid && b_r;  b_out = b_v && b_i_ready;  b_fl = b_i_flush;  b_ir = b_i_ready;
    b_c = b_i_ctrl;  b_d = b_i_data;
    @(posedge clk);

    if (a_v && !a_ir) a_stall = sat(a_stall, 15);
    if (a_fl) a_flush = sat(a_flush, 15);
    if (a_fl) qa.delete();
    else begin
      if (a_out) void'(qa.pop_front());
      if (a_in) qa.push_back(beat_t'({a_c, a_d}));
    end
    if (qa.size() > 0) a_last = qa[0].d;

    if (b_v && !b_ir) b_stall = sat(b_stall, 65535);
    if (b_fl) b_flush = sat(b_flush, 65535);
    if (b_fl) qb.delete();
    else begin
      if (b_out) void'(qb.pop_front());
      if (b_in) qb.push_back(beat_t'({b_c, b_d}));
    end
    #1;
  endtask

  task automatic send_a(input logic [CW-1:0] c);
    a_i_valid = 1'b1;
    a_i_ctrl  = c;
    a_i_data  = {$urandom, $urandom};
    cyc();
  endtask

  initial begin
    arst = 1'b1;
    a_i_flush = 0; a_i_valid = 0; a_i_ready = 0; a_i_ctrl = '0; a_i_data = '0;
    b_i_flush = 0; b_i_valid = 0; b_i_ready = 0; b_i_ctrl = '0; b_i_data = '0;
    clear_models();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", a_o_valid, 1'b0);
    chk("rst_a_ctrl", a_o_ctrl, '0);
    chk("rst_a_data", a_o_data, '0);
    chk("rst_a_occ", a_o_occ, 2'd0);
    chk("rst_b_valid", b_o_valid, 1'b0);
    arst = 1'b0;
    cyc();

    // Streaming at one beat per cycle
    a_i_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send_a(CW'(i));
    a_i_valid = 1'b0;
    repeat (2) cyc();

    // Backpressure fills the skid entry, then drains in order
    a_i_ready = 1'b0;
    send_a(16'h000A);
    send_a(16'h000B);
    a_i_valid = 1'b0;
    repeat (3) cyc();
    a_i_ready = 1'b1;
    repeat (3) cyc();

    // Flush while full, with a competing input beat
    a_i_ready = 1'b0;
    send_a(16'h0001);
    send_a(16'h0002);
    a_i_flush = 1'b1;
    send_a(16'h000C);
    a_i_flush = 1'b0;
    a_i_valid = 1'b0;
    repeat (2) cyc();

    // Flush coinciding with both an accepted output and an offered input
    a_i_ready = 1'b1;
    send_a(16'h0011);
    a_i_flush = 1'b1;
    send_a(16'h0022);
    a_i_flush = 1'b0;
    a_i_valid = 1'b0;
    repeat (2) cyc();

    // Asynchronous reset while a beat is presented
    a_i_ready = 1'b0;
    send_a(16'h0033);
    arst = 1'b1;
    #1;
    chk("arst_a_valid", a_o_valid, 1'b0);
    chk("arst_a_ctrl", a_o_ctrl, '0);
    chk("arst_a_data", a_o_data, '0);
    chk("arst_a_occ", a_o_occ, 2'd0);
    chk("arst_a_stall", a_stall_cnt, 4'd0);
    chk("arst_a_flush", a_flush_cnt, 4'd0);
    a_i_valid = 1'b0;
    clear_models();
    #1;
    arst = 1'b0;
    @(posedge clk);
    #1;
    cyc();

    // Stall counter saturates at 15
    send_a(16'h0044);
    a_i_valid = 1'b0;
    repeat (20) cyc();
    a_i_ready = 1'b1;
    repeat (2) cyc();

    // Combinational-ready instance
    b_i_ready = 1'b0;
    b_i_valid = 1'b1; b_i_ctrl = 16'h0003; b_i_data = {$urandom, $urandom};
    cyc();
    b_i_ctrl = 16'h0004; b_i_data = {$urandom, $urandom};
    cyc();
    b_i_ready = 1'b1;
    b_i_ctrl = 16'h0005; b_i_data = {$urandom, $urandom};
    cyc();
    b_i_valid = 1'b0;
    cyc();
    b_i_flush = 1'b1;
    cyc();
    b_i_flush = 1'b0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
